// File: rtl/shift_pkg.sv
// Shared mode encodings for the parameterised shift register and its bench.
package shift_pkg;

    localparam logic [2:0] MODE_HOLD = 3'b000;
    localparam logic [2:0] MODE_SHL  = 3'b001;
    localparam logic [2:0] MODE_SHR  = 3'b010;
    localparam logic [2:0] MODE_ROL  = 3'b011;
    localparam logic [2:0] MODE_ROR  = 3'b100;
    localparam logic [2:0] MODE_LOAD = 3'b101;

    // True for the four modes that move one bit per edge and advance the count.
    function automatic logic is_shift(input logic [2:0] mode);
        return (mode == MODE_SHL) || (mode == MODE_SHR) ||
               (mode == MODE_ROL) || (mode == MODE_ROR);
    endfunction

endpackage

// File: rtl/shift_cnt.sv
// Shift counter: counts shift/rotate edges within a word and pulses done
// for one cycle when a full WIDTH-bit word has been shifted.
module shift_cnt #(
    parameter int WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         step,
    input  logic                         load,
    input  logic                         clr,
    output logic [$clog2(WIDTH+1)-1:0]   cnt,
    output logic                         done
);

    localparam int CW = $clog2(WIDTH+1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    // Count register and done pulse; clear and load restart the word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            done <= 1'b0;
        end else if (clr || load) begin
            cnt  <= '0;
            done <= 1'b0;
        end else if (step) begin
            if (cnt == LAST) begin
                cnt  <= '0;
                done <= 1'b1;
            end else begin
                cnt  <= cnt + 1'b1;
                done <= 1'b0;
            end
        end else begin
            done <= 1'b0;
        end
    end

endmodule

// File: rtl/param_shift_reg.sv
// Parameterised shift/rotate register with parallel load, serial output,
// synchronous clear and a per-word completion pulse.
module param_shift_reg #(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         en,
    input  logic                         clr,
    input  logic [2:0]                   mode,
    input  logic                         sin,
    input  logic [WIDTH-1:0]             pdin,
    output logic [WIDTH-1:0]             q,
    output logic                         sout,
    output logic [$clog2(WIDTH+1)-1:0]   cnt,
    output logic                         done
);

    import shift_pkg::*;

    logic step;
    logic load;

    // Counter qualifiers: only enabled shift/rotate edges advance the count.
    assign step = en && is_shift(mode);
    assign load = en && (mode == MODE_LOAD);

    // Data register and serial output; clear outranks enable and mode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q    <= RST_VAL;
            sout <= 1'b0;
        end else if (clr) begin
            q    <= RST_VAL;
            sout <= 1'b0;
        end else if (en) begin
            case (mode)
                MODE_SHL: begin
                    q    <= {q[WIDTH-2:0], sin};
                    sout <= q[WIDTH-1];
                end
                MODE_SHR: begin
                    q    <= {sin, q[WIDTH-1:1]};
                    sout <= q[0];
                end
                MODE_ROL: begin
                    q    <= {q[WIDTH-2:0], q[WIDTH-1]};
                    sout <= q[WIDTH-1];
                end
                MODE_ROR: begin
                    q    <= {q[0], q[WIDTH-1:1]};
                    sout <= q[0];
                end
                MODE_LOAD: begin
                    q    <= pdin;
                end
                default: begin
                    // HOLD and the reserved encodings keep everything.
                end
            endcase
        end
    end

    shift_cnt #(
        .WIDTH (WIDTH)
    ) u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .step  (step),
        .load  (load),
        .clr   (clr),
        .cnt   (cnt),
        .done  (done)
    );

endmodule
